// File: rtl/nap_timer.sv
// Power-nap countdown: loads MM:SS, decrements once per TICK_DIV cycles while enabled, latches completion.
// Optional last-minute warn output is built only when NAP_TIMER_WARN_EN is defined.
module nap_timer #(
    parameter int TICK_DIV = 1000,
    parameter int MAX_MIN  = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       init,
    input  logic       enCancel,
    input  logic       enSleep,
    input  logic       load_valid,
    input  logic [6:0] load_min,
    output logic       completeSleep,
    output logic       running,
    output logic [6:0] min_left,
    output logic [5:0] sec_left,
    output logic       tick,
    output logic       warn
);

    localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]      MAX_M   = 7'(MAX_MIN);

    typedef enum logic [1:0] {IDLE, ARMED, COUNT, DONE} state_t;

    state_t        state_q;
    logic [PW-1:0] prescale_q;
    logic [6:0]    min_q;
    logic [5:0]    sec_q;
    logic          complete_q;
    logic          running_q;
    logic          tick_q;

    logic [6:0]    load_clamped;
    logic [6:0]    min_dec;
    logic [5:0]    sec_dec;
    logic          at_zero;
    logic          dec_zero;
    logic          clear_req;
    logic          sec_step;

    always_comb begin
        load_clamped = (load_min > MAX_M) ? MAX_M : load_min;
        at_zero      = (min_q == 7'd0) && (sec_q == 6'd0);
        clear_req    = init || enCancel;
        if (sec_q == 6'd0) begin
            min_dec = min_q - 7'd1;
            sec_dec = 6'd59;
        end else begin
            min_dec = min_q;
            sec_dec = sec_q - 6'd1;
        end
        dec_zero = (min_dec == 7'd0) && (sec_dec == 6'd0);
        // A decrement happens only on the last prescale cycle of an enabled, non-zero count.
        sec_step = (state_q == COUNT) && enSleep && (prescale_q == PS_LAST) && !at_zero;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prescale_q <= '0;
            min_q      <= 7'd0;
            sec_q      <= 6'd0;
            complete_q <= 1'b0;
            running_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (clear_req) begin
                state_q    <= IDLE;
                prescale_q <= '0;
                min_q      <= 7'd0;
                sec_q      <= 6'd0;
                complete_q <= 1'b0;
                running_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, ARMED: begin
                        if (load_valid) begin
                            min_q   <= load_clamped;
                            sec_q   <= 6'd0;
                            state_q <= ARMED;
                        end else if (state_q == ARMED && enSleep) begin
                            state_q    <= COUNT;
                            prescale_q <= '0;
                            running_q  <= 1'b1;
                        end
                    end
                    COUNT: begin
                        // A zero load finishes immediately without producing a tick.
                        if (at_zero) begin
                            state_q    <= DONE;
                            complete_q <= 1'b1;
                            running_q  <= 1'b0;
                        end else if (enSleep) begin
                            if (prescale_q == PS_LAST) begin
                                prescale_q <= '0;
                                tick_q     <= 1'b1;
                                min_q      <= min_dec;
                                sec_q      <= sec_dec;
                                if (dec_zero) begin
                                    state_q    <= DONE;
                                    complete_q <= 1'b1;
                                    running_q  <= 1'b0;
                                end
                            end else begin
                                prescale_q <= prescale_q + PW'(1);
                            end
                        end
                    end
                    DONE: begin
                        complete_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef NAP_TIMER_WARN_EN
    logic warn_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            warn_q <= 1'b0;
        end else if (clear_req) begin
            warn_q <= 1'b0;
        end else if (sec_step) begin
            warn_q <= (min_dec == 7'd0) && (sec_dec != 6'd0);
        end else if (state_q != COUNT) begin
            warn_q <= 1'b0;
        end
    end

    assign warn = warn_q;
`else
    assign warn = 1'b0;
`endif

    assign completeSleep = complete_q;
    assign running       = running_q;
    assign min_left      = min_q;
    assign sec_left      = sec_q;
    assign tick          = tick_q;

endmodule
